// File: rtl/hw_qsys_pio_out_gen.sv
// Avalon-MM output PIO with atomic set/clear/toggle and a registered read path.
// Define HW_QSYS_PIO_BLINK_EN to add per-bit hardware blink with a prescaler.
module hw_qsys_pio_out_gen #(
    parameter int                 DATA_W      = 8,
    parameter int                 PRESCALE_W  = 24,
    parameter logic [DATA_W-1:0]  RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port
);

    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_next;
    logic [DATA_W-1:0] out_next;
    logic [31:0]       rd_val;
    logic              unused_wd;

    assign wr = chipselect & ~write_n;
    assign rd = chipselect & ~read_n;
    assign wd = writedata[DATA_W-1:0];
    assign unused_wd = &{1'b0, writedata};

    always_comb begin
        data_next = data_q;
        if (wr) begin
            case (address)
                3'd0:    data_next = wd;
                3'd4:    data_next = data_q | wd;
                3'd5:    data_next = data_q & ~wd;
                3'd6:    data_next = data_q ^ wd;
                default: data_next = data_q;
            endcase
        end
    end

`ifdef HW_QSYS_PIO_BLINK_EN
    logic [DATA_W-1:0]     mask_q;
    logic [DATA_W-1:0]     mask_next;
    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_next;
    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_next;
    logic                  phase_q;
    logic                  phase_next;
    logic                  pre_wr;
    logic                  tick;

    assign pre_wr    = wr && (address == 3'd2);
    assign tick      = (cnt_q == pre_q);
    assign mask_next = (wr && address == 3'd1) ? wd : mask_q;
    assign pre_next  = pre_wr ? writedata[PRESCALE_W-1:0] : pre_q;

    // A prescale write restarts the blink cycle and suppresses any tick.
    always_comb begin
        cnt_next   = cnt_q + 1'b1;
        phase_next = phase_q;
        if (pre_wr) begin
            cnt_next   = '0;
            phase_next = 1'b0;
        end else if (tick) begin
            cnt_next   = '0;
            phase_next = ~phase_q;
        end
    end

    assign out_next = data_next ^ (mask_next & {DATA_W{phase_next}});

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            mask_q  <= mask_next;
            pre_q   <= pre_next;
            cnt_q   <= cnt_next;
            phase_q <= phase_next;
        end
    end
`else
    assign out_next = data_next;
`endif

    always_comb begin
        rd_val = '0;
        case (address)
            3'd0:    rd_val = 32'(data_q);
`ifdef HW_QSYS_PIO_BLINK_EN
            3'd1:    rd_val = 32'(mask_q);
            3'd2:    rd_val = 32'(pre_q);
`endif
            3'd3:    rd_val = 32'(out_port);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= RESET_VALUE;
            out_port <= RESET_VALUE;
            readdata <= '0;
        end else begin
            data_q   <= data_next;
            out_port <= out_next;
            if (rd) begin
                readdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_hw_qsys_pio_out_gen.sv
// Directed bench for hw_qsys_pio_out_gen: 8-bit and 32-bit instances on one bus.
// Blink scenarios run when HW_QSYS_PIO_BLINK_EN is defined.
module tb_hw_qsys_pio_out_gen;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rdata_a;
    logic [7:0]  out_a;
    logic [31:0] rdata_b;
    logic [31:0] out_b;

    int errors;
    int checks;

    hw_qsys_pio_out_gen #(
        .DATA_W(8), .PRESCALE_W(24), .RESET_VALUE(8'hA5)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(rdata_a), .out_port(out_a)
    );

    hw_qsys_pio_out_gen #(
        .DATA_W(32), .PRESCALE_W(4), .RESET_VALUE(32'h1234_5678)
    ) dut_b (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(rdata_b), .out_port(out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus tasks are entered at a falling edge and return at the next one.
    task automatic bus_write(input logic cs, input logic [2:0] a,
                             input logic [31:0] d);
        chipselect = cs;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_a !== 8'hA5) begin
            errors++; $display("FAIL reset_out got %h want a5", out_a);
        end
        checks++;
        if (rdata_a !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", rdata_a);
        end
        checks++;
        if (out_b !== 32'h1234_5678) begin
            errors++; $display("FAIL reset_out_b got %h want 12345678", out_b);
        end
        reset = 1'b0;
        @(negedge clk);
        bus_read(3'd0);
        checks++;
        if (rdata_a !== 32'h0000_00A5) begin
            errors++; $display("FAIL reset_read0 got %h want 000000a5", rdata_a);
        end
    endtask

    task automatic test_set_clear_toggle;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0F;
        #3;
        checks++;
        if (out_a !== 8'hA5) begin
            errors++; $display("FAIL pre_edge_out got %h want a5", out_a);
        end
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        checks++;
        if (out_a !== 8'h0F) begin
            errors++; $display("FAIL data_wr got %h want 0f", out_a);
        end
        bus_write(1'b1, 3'd4, 32'hF0);
        checks++;
        if (out_a !== 8'hFF) begin
            errors++; $display("FAIL outset got %h want ff", out_a);
        end
        bus_write(1'b1, 3'd5, 32'h03);
        checks++;
        if (out_a !== 8'hFC) begin
            errors++; $display("FAIL outclear got %h want fc", out_a);
        end
        bus_write(1'b1, 3'd6, 32'h81);
        checks++;
        if (out_a !== 8'h7D) begin
            errors++; $display("FAIL outtoggle got %h want 7d", out_a);
        end
        bus_read(3'd3);
        checks++;
        if (rdata_a !== 32'h7D) begin
            errors++; $display("FAIL status_rd got %h want 7d", rdata_a);
        end
        for (int a = 4; a <= 6; a++) begin
            bus_read(3'(a));
            checks++;
            if (rdata_a !== 32'h0) begin
                errors++; $display("FAIL wo_read%0d got %h want 0", a, rdata_a);
            end
        end
    endtask

    task automatic test_rw_same;
        bus_write(1'b1, 3'd0, 32'h12);
        chipselect = 1'b1;
        read_n     = 1'b0;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h34;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        checks++;
        if (rdata_a !== 32'h12) begin
            errors++; $display("FAIL rw_rdata got %h want 12", rdata_a);
        end
        checks++;
        if (out_a !== 8'h34) begin
            errors++; $display("FAIL rw_out got %h want 34", out_a);
        end
    endtask

`ifdef HW_QSYS_PIO_BLINK_EN
    task automatic test_blink_slow;
        logic [7:0] exp;
        bus_write(1'b1, 3'd0, 32'h10);
        bus_write(1'b1, 3'd1, 32'h01);
        bus_write(1'b1, 3'd2, 32'h3);
        for (int k = 0; k < 6; k++) begin
            exp = ((k / 4) % 2 == 1) ? 8'h11 : 8'h10;
            checks++;
            if (out_a !== exp) begin
                errors++; $display("FAIL blink_slow k=%0d got %h want %h", k, out_a, exp);
            end
            @(negedge clk);
        end
        bus_write(1'b1, 3'd2, 32'h3);
        checks++;
        if (out_a !== 8'h10) begin
            errors++; $display("FAIL blink_restart got %h want 10", out_a);
        end
    endtask

    task automatic test_blink_fast;
        logic [7:0] exp;
        bus_write(1'b1, 3'd0, 32'h00);
        bus_write(1'b1, 3'd1, 32'hFF);
        bus_write(1'b1, 3'd2, 32'h0);
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 1) ? 8'hFF : 8'h00;
            checks++;
            if (out_a !== exp) begin
                errors++; $display("FAIL blink_fast k=%0d got %h want %h", k, out_a, exp);
            end
            @(negedge clk);
        end
        bus_write(1'b1, 3'd6, 32'hFF);
        checks++;
        if (out_a !== 8'h00) begin
            errors++; $display("FAIL tick_toggle_out got %h want 00", out_a);
        end
        bus_read(3'd0);
        checks++;
        if (rdata_a !== 32'hFF) begin
            errors++; $display("FAIL tick_toggle_data got %h want ff", rdata_a);
        end
        bus_write(1'b1, 3'd1, 32'h0);
        bus_write(1'b1, 3'd2, 32'hFFFF_FFFF);
        bus_read(3'd2);
        checks++;
        if (rdata_a !== 32'h00FF_FFFF) begin
            errors++; $display("FAIL pre_rd_a got %h want 00ffffff", rdata_a);
        end
        checks++;
        if (rdata_b !== 32'h0000_000F) begin
            errors++; $display("FAIL pre_rd_b got %h want 0000000f", rdata_b);
        end
        bus_read(3'd1);
        checks++;
        if (rdata_a !== 32'h0) begin
            errors++; $display("FAIL mask_rd got %h want 0", rdata_a);
        end
    endtask
`else
    task automatic test_no_blink;
        bus_write(1'b1, 3'd1, 32'hFF);
        bus_write(1'b1, 3'd2, 32'hFF);
        repeat (3) @(negedge clk);
        checks++;
        if (out_a !== 8'h34) begin
            errors++; $display("FAIL noblink_out got %h want 34", out_a);
        end
        bus_read(3'd1);
        checks++;
        if (rdata_a !== 32'h0) begin
            errors++; $display("FAIL noblink_rd1 got %h want 0", rdata_a);
        end
        bus_read(3'd2);
        checks++;
        if (rdata_a !== 32'h0) begin
            errors++; $display("FAIL noblink_rd2 got %h want 0", rdata_a);
        end
    endtask
`endif

    task automatic test_ignored;
        bus_write(1'b1, 3'd0, 32'h5A);
        bus_read(3'd0);
        bus_write(1'b0, 3'd0, 32'h55);
        bus_write(1'b0, 3'd4, 32'hFF);
        bus_write(1'b1, 3'd3, 32'hFF);
        bus_write(1'b1, 3'd7, 32'hFF);
        checks++;
        if (out_a !== 8'h5A) begin
            errors++; $display("FAIL ignored_out got %h want 5a", out_a);
        end
        chipselect = 1'b0;
        read_n     = 1'b0;
        address    = 3'd7;
        @(negedge clk);
        read_n     = 1'b1;
        checks++;
        if (rdata_a !== 32'h5A) begin
            errors++; $display("FAIL rd_hold got %h want 5a", rdata_a);
        end
        bus_read(3'd7);
        checks++;
        if (rdata_a !== 32'h0) begin
            errors++; $display("FAIL rsvd_rd got %h want 0", rdata_a);
        end
    endtask

    task automatic test_reset_mid;
`ifdef HW_QSYS_PIO_BLINK_EN
        bus_write(1'b1, 3'd1, 32'hFF);
        bus_write(1'b1, 3'd2, 32'h0);
`endif
        bus_read(3'd0);
        reset      = 1'b1;
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 3'd0;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        checks++;
        if (out_a !== 8'hA5) begin
            errors++; $display("FAIL midreset_out got %h want a5", out_a);
        end
        checks++;
        if (rdata_a !== 32'h0) begin
            errors++; $display("FAIL midreset_rdata got %h want 0", rdata_a);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_a !== 8'hA5) begin
            errors++; $display("FAIL post_reset_out got %h want a5", out_a);
        end
    endtask

    task automatic test_wide;
        bus_write(1'b1, 3'd0, 32'hDEAD_BEEF);
        checks++;
        if (out_b !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wide_out got %h want deadbeef", out_b);
        end
        checks++;
        if (out_a !== 8'hEF) begin
            errors++; $display("FAIL narrow_out got %h want ef", out_a);
        end
        bus_read(3'd0);
        checks++;
        if (rdata_a !== 32'h0000_00EF) begin
            errors++; $display("FAIL narrow_rd got %h want 000000ef", rdata_a);
        end
        bus_write(1'b1, 3'd5, 32'hFFFF_0000);
        bus_read(3'd3);
        checks++;
        if (rdata_b !== 32'h0000_BEEF) begin
            errors++; $display("FAIL wide_clear got %h want 0000beef", rdata_b);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        @(negedge clk);
        test_reset;
        test_set_clear_toggle;
        test_rw_same;
`ifdef HW_QSYS_PIO_BLINK_EN
        test_blink_slow;
        test_blink_fast;
`else
        test_no_blink;
`endif
        test_ignored;
        test_reset_mid;
        test_wide;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
